bcd_seg7_scanner: RTL

//  Downstream display stage for the multiplier. Captures its packed BCD product on the rising edge of finish
//  and time-multiplexes the digits onto a common-anode 7-segment bank: one digit lit per scan slot.

---
 rtl/bcd_seg7_scanner_pkg.sv | 26 ++
 rtl/bcd_seg7_scanner_if.sv | 30 +++
 rtl/bcd_seg7_scanner_seg7_decode.sv | 26 ++
 rtl/bcd_seg7_scanner.sv | 112 +++++++++++
 4 files changed

// File: rtl/bcd_seg7_scanner_pkg.sv
// Shared constants for the BCD 7-segment scanner: active-low segment codes and digit-count helper.
package bcd_seg7_scanner_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Decimal digits needed for the product of two N-bit operands
    function automatic int unsigned digits_for(input int unsigned n);
        return ((2 * n) / 3) + 1;
    endfunction

endpackage

// File: rtl/bcd_seg7_scanner_if.sv
// Display-side bus: BCD product and capture strobe in, multiplexed segment/anode drive out.
interface bcd_seg7_scanner_if
    import bcd_seg7_scanner_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) ();

    logic [DIGITS*NIB_W-1:0] bcd_in;
    logic                    load;
    logic [SEG_W-1:0]        seg;
    logic [DIGITS-1:0]       an;
    logic                    valid;

    modport master (
        output bcd_in,
        output load,
        input  seg,
        input  an,
        input  valid
    );

    modport slave (
        input  bcd_in,
        input  load,
        output seg,
        output an,
        output valid
    );

endinterface

// File: rtl/bcd_seg7_scanner_seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder; any non-BCD nibble shows 'E'.
module seg7_decode
    import bcd_seg7_scanner_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_E;
        case (nib)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Captures a packed BCD value on the rising edge of load and scans it, one digit per slot,
// onto a common-anode 7-segment bank with leading-zero blanking.
module bcd_seg7_scanner
    import bcd_seg7_scanner_pkg::*;
#(
    parameter int unsigned N           = 5,
    parameter int unsigned DIGITS      = digits_for(N),
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    bcd_seg7_scanner_if.slave  bus
);

    localparam int unsigned BCD_W = DIGITS * NIB_W;
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end

    logic                load_q;
    logic                cap_en_c;
    logic [BCD_W-1:0]    cap_reg;
    logic                valid_q;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick_c;
    logic [IDX_W-1:0]    digit_idx;
    logic [DIGITS-1:0]   blank_c;
    logic                blank_sel_c;
    logic [NIB_W-1:0]    nib_c;
    logic [SEG_W-1:0]    dec_seg_c;
    logic [SEG_W-1:0]    seg_d_c;
    logic [DIGITS-1:0]   an_d_c;
    logic [SEG_W-1:0]    seg_q;
    logic [DIGITS-1:0]   an_q;

    assign cap_en_c = bus.load & ~load_q;

    // Edge detect and capture register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q  <= 1'b0;
            cap_reg <= '0;
            valid_q <= 1'b0;
        end else begin
            load_q <= bus.load;
            if (cap_en_c) begin
                cap_reg <= bus.bcd_in;
                valid_q <= 1'b1;
            end
        end
    end

    assign tick_c = (div_cnt == DIV_W'(REFRESH_DIV - 1));

    // Slot divider and digit pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) begin
                digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end
        end
    end

    // A digit is blank when it and every more-significant digit are zero; digit 0 always shows
    assign blank_c[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_blank
        assign blank_c[i] = ~|cap_reg[BCD_W-1:i*NIB_W];
    end

    always_comb begin
        nib_c       = '0;
        blank_sel_c = 1'b0;
        an_d_c      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nib_c       = cap_reg[i*NIB_W +: NIB_W];
                blank_sel_c = blank_c[i];
                an_d_c[i]   = blank_c[i];
            end
        end
    end

    seg7_decode u_decode (
        .nib   (nib_c),
        .seg_c (dec_seg_c)
    );

    assign seg_d_c = blank_sel_c ? SEG_OFF : dec_seg_c;

    // Output registers: one clk behind the digit pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d_c;
            an_q  <= an_d_c;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.valid = valid_q;

endmodule
